// File: rtl/mem_arb_pkg.sv
// Shared definitions for mem_port_arbiter: FSM state encoding, grant ids and a
// saturating increment used by the optional performance counters.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } arb_state_t;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_D  = 1'b1;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
    return (en && (v != '1)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/mem_arb_perf.sv
// Saturating event counters for mem_port_arbiter (fetch stalls, data stalls,
// arbitration conflicts); only instantiated when ARB_PERF_CNT_EN is defined.
module mem_arb_perf
  import mem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_if_stall,
  input  logic        i_d_stall,
  input  logic        i_conflict,
  output logic [31:0] o_if_stall_cnt,
  output logic [31:0] o_d_stall_cnt,
  output logic [31:0] o_conflict_cnt
);

  logic [31:0] r_if_stall_cnt;
  logic [31:0] r_d_stall_cnt;
  logic [31:0] r_conflict_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_if_stall_cnt <= '0;
      r_d_stall_cnt  <= '0;
      r_conflict_cnt <= '0;
    end else begin
      r_if_stall_cnt <= sat_inc32(r_if_stall_cnt, i_if_stall);
      r_d_stall_cnt  <= sat_inc32(r_d_stall_cnt, i_d_stall);
      r_conflict_cnt <= sat_inc32(r_conflict_cnt, i_conflict);
    end
  end

  assign o_if_stall_cnt = r_if_stall_cnt;
  assign o_d_stall_cnt  = r_d_stall_cnt;
  assign o_conflict_cnt = r_conflict_cnt;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between fetch and data
// ports, with optional wait timeout. Define ARB_PERF_CNT_EN for perf counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              if_err,
  output logic              d_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_if_stall,
  output logic [31:0]       perf_d_stall,
  output logic [31:0]       perf_conflict
`endif
);

  localparam int unsigned CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (MAX_WAIT > 0) ? CNT_W'(MAX_WAIT - 1) : '0;

  arb_state_t        r_state;
  logic              r_last_gnt;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_if_valid, r_d_valid, r_if_err, r_d_err;
  logic [DATA_W-1:0] r_if_rdata, r_d_rdata;
  logic              r_mem_req, r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic w_if_elig, w_d_elig, w_gnt_any, w_gnt_d, w_done, w_timeout;

  // A port is ignored in the cycle its completion pulse is out, so a requester
  // that only drops req after seeing the pulse is never served twice.
  assign w_if_elig = if_req & ~r_if_valid & ~r_if_err;
  assign w_d_elig  = d_req & ~r_d_valid & ~r_d_err;
  assign w_gnt_any = w_if_elig | w_d_elig;
  assign w_gnt_d   = w_d_elig & (~w_if_elig | (r_last_gnt == GNT_IF));
  assign w_done    = mem_ready & r_mem_req;
  assign w_timeout = (MAX_WAIT > 0) && (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_last_gnt  <= GNT_D;
      r_cnt       <= '0;
      r_if_valid  <= 1'b0;
      r_d_valid   <= 1'b0;
      r_if_err    <= 1'b0;
      r_d_err     <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
      r_if_err   <= 1'b0;
      r_d_err    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_gnt_any) begin
            r_state    <= w_gnt_d ? BUSY_D : BUSY_IF;
            r_last_gnt <= w_gnt_d ? GNT_D : GNT_IF;
            r_cnt      <= '0;
            r_mem_req  <= 1'b1;
            r_mem_we   <= w_gnt_d & d_we;
            r_mem_addr <= w_gnt_d ? d_addr : if_addr;
            if (w_gnt_d) r_mem_wdata <= d_wdata;
          end
        end
        BUSY_IF, BUSY_D: begin
          if (w_done) begin
            r_mem_req <= 1'b0;
            r_state   <= IDLE;
            if (r_state == BUSY_IF) begin
              r_if_rdata <= mem_rdata;
              r_if_valid <= 1'b1;
            end else begin
              if (!r_mem_we) r_d_rdata <= mem_rdata;
              r_d_valid <= 1'b1;
            end
          end else if (w_timeout) begin
            r_mem_req <= 1'b0;
            r_state   <= IDLE;
            r_cnt     <= r_cnt + CNT_W'(1);
            if (r_state == BUSY_IF) r_if_err <= 1'b1;
            else                    r_d_err  <= 1'b1;
          end else if (MAX_WAIT > 0) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign if_valid  = r_if_valid;
  assign if_rdata  = r_if_rdata;
  assign d_valid   = r_d_valid;
  assign d_rdata   = r_d_rdata;
  assign if_err    = r_if_err;
  assign d_err     = r_d_err;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

`ifdef ARB_PERF_CNT_EN
  logic w_if_stall, w_d_stall, w_conflict;

  assign w_if_stall = if_req & ~r_if_valid;
  assign w_d_stall  = d_req & ~r_d_valid;
  assign w_conflict = (r_state == IDLE) & w_if_elig & w_d_elig;

  mem_arb_perf u_perf (
    .clk            (clk),
    .reset          (reset),
    .i_if_stall     (w_if_stall),
    .i_d_stall      (w_d_stall),
    .i_conflict     (w_conflict),
    .o_if_stall_cnt (perf_if_stall),
    .o_d_stall_cnt  (perf_d_stall),
    .o_conflict_cnt (perf_conflict)
  );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (MAX_WAIT=4): directed scenarios plus
// a randomized run against a transaction-level model; perf checks with ARB_PERF_CNT_EN.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, d_req, d_we, mem_ready;
  logic [AW-1:0] if_addr, d_addr, mem_addr;
  logic [DW-1:0] d_wdata, mem_rdata, if_rdata, d_rdata, mem_wdata;
  logic          if_valid, d_valid, if_err, d_err, mem_req, mem_we;
`ifdef ARB_PERF_CNT_EN
  logic [31:0]   perf_if_stall, perf_d_stall, perf_conflict;
  int unsigned   exp_if_stall, exp_d_stall, exp_conflict;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_valid  (if_valid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_valid   (d_valid),
    .d_rdata   (d_rdata),
    .if_err    (if_err),
    .d_err     (d_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
`ifdef ARB_PERF_CNT_EN
    ,
    .perf_if_stall (perf_if_stall),
    .perf_d_stall  (perf_d_stall),
    .perf_conflict (perf_conflict)
`endif
  );

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic tick();
`ifdef ARB_PERF_CNT_EN
    if (!reset && if_req && !if_valid) exp_if_stall++;
    if (!reset && d_req && !d_valid) exp_d_stall++;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    tick();
    tick();
    reset = 1'b0;
`ifdef ARB_PERF_CNT_EN
    exp_if_stall = 0; exp_d_stall = 0; exp_conflict = 0;
`endif
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({mem_req, mem_we, if_valid, d_valid, if_err, d_err} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b, want 000000", {mem_req, mem_we, if_valid, d_valid, if_err, d_err});
    end
    n_checks++;
    if (mem_addr !== '0 || mem_wdata !== '0 || if_rdata !== '0 || d_rdata !== '0) begin
      n_fail++;
      $display("FAIL reset_data: addr=%h wdata=%h if_rdata=%h d_rdata=%h, want all 0", mem_addr, mem_wdata, if_rdata, d_rdata);
    end
    mem_ready = 1'b1;
    mem_rdata = 32'hFFFF_0000;
    tick();
    tick();
    n_checks++;
    if ({mem_req, if_valid, d_valid, if_err, d_err} !== 5'b0 || d_rdata !== '0) begin
      n_fail++;
      $display("FAIL idle_ready_ignored: ctrl=%b d_rdata=%h, want 00000 and 0", {mem_req, if_valid, d_valid, if_err, d_err}, d_rdata);
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_single_fetch();
    do_reset();
    if_req = 1'b1; if_addr = 32'h40;
    tick();
    n_checks++;
    if ({mem_req, mem_we, if_valid} !== 3'b100 || mem_addr !== 32'h40) begin
      n_fail++;
      $display("FAIL fetch_issue: req/we/valid=%b addr=%h, want 100 addr=00000040", {mem_req, mem_we, if_valid}, mem_addr);
    end
    tick();
    n_checks++;
    if ({mem_req, if_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL fetch_wait: req/valid=%b, want 10", {mem_req, if_valid});
    end
    mem_ready = 1'b1; mem_rdata = 32'h2008000A;
    tick();
    mem_ready = 1'b0; mem_rdata = '0;
    n_checks++;
    if ({mem_req, if_valid, d_valid} !== 3'b010 || if_rdata !== 32'h2008000A) begin
      n_fail++;
      $display("FAIL fetch_done: req/ifv/dv=%b rdata=%h, want 010 rdata=2008000a", {mem_req, if_valid, d_valid}, if_rdata);
    end
    tick();
    n_checks++;
    if ({mem_req, if_valid} !== 2'b00 || if_rdata !== 32'h2008000A) begin
      n_fail++;
      $display("FAIL fetch_no_double: req/valid=%b rdata=%h, want 00 rdata=2008000a", {mem_req, if_valid}, if_rdata);
    end
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_conflict();
    logic        exp_d;
    logic [31:0] rd;
    do_reset();
    if_addr = 32'h80; d_addr = 32'h200; d_we = 1'b0;
    if_req = 1'b1; d_req = 1'b1;
    for (int n = 0; n < 4; n++) begin
      exp_d = (n % 2 == 1);
      rd = 32'hA000_0000 + 32'(n);
      tick();
      n_checks++;
      if (mem_req !== 1'b1 || mem_addr !== (exp_d ? 32'h200 : 32'h80)) begin
        n_fail++;
        $display("FAIL conflict_grant[%0d]: req=%b addr=%h, want 1 addr=%h", n, mem_req, mem_addr, exp_d ? 32'h200 : 32'h80);
      end
      tick();
      mem_ready = 1'b1; mem_rdata = rd;
      tick();
      mem_ready = 1'b0;
      n_checks++;
      if ({if_valid, d_valid, mem_req} !== {~exp_d, exp_d, 1'b0} || (exp_d ? d_rdata : if_rdata) !== rd) begin
        n_fail++;
        $display("FAIL conflict_done[%0d]: ifv/dv/req=%b rdata=%h, want %b rdata=%h", n, {if_valid, d_valid, mem_req}, exp_d ? d_rdata : if_rdata, {~exp_d, exp_d, 1'b0}, rd);
      end
      if (n == 3) begin if_req = 1'b0; d_req = 1'b0; end
    end
    tick();
    n_checks++;
    if (mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL conflict_quiet: req=%b, want 0", mem_req);
    end
`ifdef ARB_PERF_CNT_EN
    n_checks++;
    if (perf_conflict !== 32'd1 || perf_if_stall !== exp_if_stall || perf_d_stall !== exp_d_stall) begin
      n_fail++;
      $display("FAIL perf_conflict_run: conflict=%0d if_stall=%0d d_stall=%0d, want 1 %0d %0d", perf_conflict, perf_if_stall, perf_d_stall, exp_if_stall, exp_d_stall);
    end
`endif
  endtask

  task automatic test_store();
    int held;
    do_reset();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h104;
    tick();
    mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_ready = 1'b0; d_req = 1'b0;
    n_checks++;
    if (d_valid !== 1'b1 || d_rdata !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL load_before_store: valid=%b rdata=%h, want 1 12345678", d_valid, d_rdata);
    end
    tick();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
    tick();
    held = (mem_req === 1'b1) ? 1 : 0;
    n_checks++;
    if ({mem_req, mem_we} !== 2'b11 || mem_addr !== 32'h100 || mem_wdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL store_issue: req/we=%b addr=%h wdata=%h, want 11 00000100 deadbeef", {mem_req, mem_we}, mem_addr, mem_wdata);
    end
    d_addr = 32'h7FC; d_wdata = 32'h0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (mem_req === 1'b1 && mem_we === 1'b1 && mem_addr === 32'h100 && mem_wdata === 32'hDEADBEEF) held++;
    end
    mem_ready = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    tick();
    mem_ready = 1'b0;
    n_checks++;
    if (held != 4 || {d_valid, mem_req, d_err} !== 3'b100 || d_rdata !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL store_done: held=%0d dv/req/err=%b d_rdata=%h, want 4 100 12345678", held, {d_valid, mem_req, d_err}, d_rdata);
    end
    d_req = 1'b0;
    tick();
    n_checks++;
    if ({d_valid, mem_req} !== 2'b00) begin
      n_fail++;
      $display("FAIL store_pulse: dv/req=%b, want 00", {d_valid, mem_req});
    end
  endtask

  task automatic test_timeout();
    int cycles;
    do_reset();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    tick();
    cycles = 0;
    while (mem_req === 1'b1 && cycles < 20) begin
      cycles++;
      tick();
    end
    n_checks++;
    if (cycles != int'(MW) || {d_err, d_valid, mem_req} !== 3'b100) begin
      n_fail++;
      $display("FAIL timeout_abort: req_cycles=%0d err/valid/req=%b, want %0d 100", cycles, {d_err, d_valid, mem_req}, MW);
    end
    tick();
    n_checks++;
    if ({d_err, d_valid, mem_req} !== 3'b000) begin
      n_fail++;
      $display("FAIL timeout_after: err/valid/req=%b, want 000", {d_err, d_valid, mem_req});
    end
    d_req = 1'b0; if_req = 1'b1; if_addr = 32'h44;
    tick();
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h44) begin
      n_fail++;
      $display("FAIL timeout_idle: req=%b addr=%h, want 1 00000044", mem_req, mem_addr);
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0; if_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    if_req = 1'b1; if_addr = 32'h10;
    tick();
    mem_ready = 1'b1; mem_rdata = 32'h1111_1111;
    tick();
    mem_ready = 1'b0; if_req = 1'b0;
    tick();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    n_checks++;
    if ({mem_req, d_valid, d_err} !== 3'b000 || if_rdata !== '0 || d_rdata !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: req/dv/err=%b if_rdata=%h d_rdata=%h, want 000 0 0", {mem_req, d_valid, d_err}, if_rdata, d_rdata);
    end
    reset = 1'b0;
    if_req = 1'b1; if_addr = 32'h30;
    tick();
    n_checks++;
    if ({mem_req, mem_we, d_valid} !== 3'b100 || mem_addr !== 32'h30) begin
      n_fail++;
      $display("FAIL reset_mid_regrant: req/we/dv=%b addr=%h, want 100 00000030", {mem_req, mem_we, d_valid}, mem_addr);
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0; if_req = 1'b0;
    tick();
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h20) begin
      n_fail++;
      $display("FAIL reset_mid_data_next: req=%b addr=%h, want 1 00000020", mem_req, mem_addr);
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0; d_req = 1'b0;
    tick();
  endtask

  // Transaction-level model: each port is idle, waiting, or in its completion
  // cycle; the memory answers after a random number of wait cycles.
  task automatic test_random();
    int unsigned pend_if, pend_d, waitc, delay;
    logic        busy, bport, last, lat_we;
    logic [31:0] lat_addr, lat_wd, exp_if_rd, exp_d_rd, rd, a_if, a_d, wd;
    logic        el_if, el_d, rdy, we;
    logic        e_req, e_ifv, e_dv, e_ife, e_de;
    do_reset();
    pend_if = 0; pend_d = 0; busy = 1'b0; last = 1'b1; waitc = 0; delay = 0;
    lat_we = 1'b0; lat_addr = '0; lat_wd = '0; exp_if_rd = '0; exp_d_rd = '0;
    for (int cyc = 0; cyc < 3000 && n_fail < 20; cyc++) begin
      if ($urandom_range(0, 7) == 0) begin
        if_addr = $urandom() & 32'h3FC; d_addr = $urandom() & 32'h3FC; d_wdata = $urandom();
      end
      el_if = 1'b0;
      if (pend_if == 2) begin
        if_req = 1'($urandom_range(0, 1)); pend_if = 0;
      end else begin
        if (pend_if == 0 && $urandom_range(0, 2) == 0) begin
          pend_if = 1; if_addr = $urandom() & 32'h3FC;
        end
        if_req = (pend_if == 1); el_if = (pend_if == 1);
      end
      el_d = 1'b0;
      if (pend_d == 2) begin
        d_req = 1'($urandom_range(0, 1)); pend_d = 0;
      end else begin
        if (pend_d == 0 && $urandom_range(0, 2) == 0) begin
          pend_d = 1; d_addr = $urandom() & 32'h3FC; d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom();
        end
        d_req = (pend_d == 1); el_d = (pend_d == 1);
      end
      mem_ready = busy ? (waitc == delay) : ($urandom_range(0, 3) == 0);
      mem_rdata = $urandom();
      rdy = mem_ready; rd = mem_rdata; a_if = if_addr; a_d = d_addr; wd = d_wdata; we = d_we;
`ifdef ARB_PERF_CNT_EN
      if (!busy && el_if && el_d) exp_conflict++;
`endif
      tick();
      e_req = 1'b0; e_ifv = 1'b0; e_dv = 1'b0; e_ife = 1'b0; e_de = 1'b0;
      if (busy) begin
        if (rdy) begin
          busy = 1'b0;
          if (!bport) begin e_ifv = 1'b1; exp_if_rd = rd; pend_if = 2; end
          else begin e_dv = 1'b1; if (!lat_we) exp_d_rd = rd; pend_d = 2; end
        end else begin
          waitc++;
          if (waitc == MW) begin
            busy = 1'b0;
            if (!bport) begin e_ife = 1'b1; pend_if = 2; end
            else begin e_de = 1'b1; pend_d = 2; end
          end else begin
            e_req = 1'b1;
          end
        end
      end else if (el_if || el_d) begin
        bport = el_d && (!el_if || last == 1'b0);
        last = bport; busy = 1'b1; waitc = 0; delay = $urandom_range(0, 5);
        lat_addr = bport ? a_d : a_if; lat_we = bport && we; lat_wd = wd; e_req = 1'b1;
      end
      n_checks++;
      if ({mem_req, if_valid, d_valid, if_err, d_err} !== {e_req, e_ifv, e_dv, e_ife, e_de}) begin
        n_fail++;
        $display("FAIL rand_ctrl[%0d]: req/ifv/dv/ife/de=%b, want %b", cyc, {mem_req, if_valid, d_valid, if_err, d_err}, {e_req, e_ifv, e_dv, e_ife, e_de});
      end
      if (e_req) begin
        n_checks++;
        if (mem_addr !== lat_addr || mem_we !== lat_we || (lat_we && mem_wdata !== lat_wd)) begin
          n_fail++;
          $display("FAIL rand_latch[%0d]: addr=%h we=%b wdata=%h, want %h %b %h", cyc, mem_addr, mem_we, mem_wdata, lat_addr, lat_we, lat_wd);
        end
      end
      n_checks++;
      if (if_rdata !== exp_if_rd || d_rdata !== exp_d_rd) begin
        n_fail++;
        $display("FAIL rand_rdata[%0d]: if=%h d=%h, want %h %h", cyc, if_rdata, d_rdata, exp_if_rd, exp_d_rd);
      end
    end
    if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    mem_ready = 1'b0;
    tick();
    n_checks++;
    if ({mem_req, if_valid, d_valid, if_err, d_err} !== 5'b0) begin
      n_fail++;
      $display("FAIL rand_drain: ctrl=%b, want 00000", {mem_req, if_valid, d_valid, if_err, d_err});
    end
`ifdef ARB_PERF_CNT_EN
    n_checks++;
    if (perf_conflict !== exp_conflict || perf_if_stall !== exp_if_stall || perf_d_stall !== exp_d_stall) begin
      n_fail++;
      $display("FAIL rand_perf: conflict=%0d if_stall=%0d d_stall=%0d, want %0d %0d %0d", perf_conflict, perf_if_stall, perf_d_stall, exp_conflict, exp_if_stall, exp_d_stall);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_conflict();
    test_store();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
